blinds_motor_ctrl: RTL and testbench
====================================

// Module: blinds_motor_ctrl
// PURPOSE
//   Downstream stage of the blinds level decision logic. Consumes the 2-bit target blind
//   level (0 = fully open .. 3 = fully closed) and drives the up/down motor to reach it.
//   Filters target glitches and enforces a motor-off dwell before every start or reversal.
//   Tracks position by step counting and reports the current level.
// PARAMETERS
//   STEPS_PER_LEVEL  100  motor steps between adjacent levels (>=2); one step per motor-on cycle
//   SETTLE           8    consecutive cycles target must hold before it is accepted (>=1)
//   DIR_DWELL        4    motor-off cycles before any start or reversal (>=1)
// PORTS
//   clk         in   1  single clock, all logic on the rising edge
//   rst         in   1  synchronous, active-high reset
//   target      in   2  requested level from the level decision stage
//   motor_up    out  1  drive blind towards open (level decreasing)
//   motor_down  out  1  drive blind towards closed (level increasing)
//   position    out  2  current level, floor of step position
//   busy        out  1  high in any state other than IDLE
//   at_target   out  1  high when position==goal and sub-step==0
// BEHAVIOUR
//   - Reset: state=IDLE, level=0, sub=0, goal=0, stab_cnt=0; motor_up=motor_down=0,
//     position=0, busy=0, at_target=1. Reset mid-move stops the motor on the next edge and
//     redefines the current position as level 0 (no homing in this block).
//   - All outputs are registered. motor_up and motor_down are never high together.
//   - Target filter: target registered into target_q. stab_cnt clears when target!=target_q,
//     else increments (saturating). On the edge where stab_cnt reaches SETTLE-1, goal<=target_q.
//     Pulses shorter than SETTLE cycles never reach goal.
//   - Position: level[1:0] plus sub[clog2(STEPS_PER_LEVEL)-1:0].
//     Down step: sub==SPL-1 ? (sub=0, level++) : sub++.
//     Up step:   sub==0 ? (sub=SPL-1, level--) : sub--.
//     position=level. Arrival = (level==goal && sub==0).
//   - FSM IDLE/DWELL/MOVE_UP/MOVE_DOWN:
//       IDLE -> DWELL when the position differs from goal; direction latched (goal>level -> down).
//       DWELL: motors off for DIR_DWELL cycles, then -> MOVE_DOWN or MOVE_UP.
//       MOVE_x: motor_x high; each edge with motor_x high commits exactly one step.
//         On the arrival edge -> IDLE and the motor is off the next cycle.
//       Goal change in MOVE_x, same direction: continue without a stop.
//       Goal change in MOVE_x, opposite direction or equal to the current position with sub!=0:
//         -> DWELL, then move in the direction needed to reach sub==0 at the goal.
//       Goal change during DWELL: the direction is re-evaluated at DWELL exit; the dwell is not restarted.
//   - Timing: from the first edge sampling a new stable target to the first motor-high cycle
//     = SETTLE + DIR_DWELL + 1 cycles, exact. The motor is then high for exactly |dlevel|*SPL cycles.
//   - Boundaries: level saturates at 0 and 3 (step commands never issued past the ends);
//     target==position while idle causes no motion; target toggling forever means motors stay off.
// STRUCTURE
//   - Shared package blinds_pkg: LEVEL_OPEN=2'd0 .. LEVEL_CLOSED=2'd3, level_t (2-bit),
//     motor state enum {IDLE,DWELL,MOVE_UP,MOVE_DOWN}. The level decision stage also uses it.
//   - One natural sub-module: blinds_target_filter (target_q, stab_cnt, goal, goal_upd strobe).
//     The FSM and step counter stay in this module.
// TESTING  (SPL=4, SETTLE=3, DIR_DWELL=2)
//   1 Reset held 2 cycles, target=0 -> all outputs 0, at_target=1, busy=0; no motor activity for 50 cycles.
//   2 Target 0->3 -> motor_down first high 6 cycles after the change and high for exactly 12 cycles;
//     position steps 1,2,3; then busy=0, at_target=1.
//   3 From level 0, target 0->2 for 2 cycles then back to 0 -> goal unchanged, motors never high.
//   4 At level 3, target->0; after 5 up steps target->3 -> motor_up drops, 2 off cycles, then
//     motor_down high 5 cycles; ends at level 3, sub 0.
//   5 Moving 0->1, target->3 mid-move (same direction) -> motor_down stays high continuously,
//     12 cycles total from the start.
//   6 rst pulse during MOVE_DOWN -> motor_down=0 the next cycle, position=0, busy=0;
//     a following target=1 moves exactly 4 steps.

Source files
------------

// File: rtl/blinds_pkg.sv
// Shared types for the blinds level decision and motor control stages.
package blinds_pkg;

  typedef logic [1:0] level_t;

  localparam level_t LEVEL_OPEN       = 2'd0;
  localparam level_t LEVEL_THIRD      = 2'd1;
  localparam level_t LEVEL_TWO_THIRDS = 2'd2;
  localparam level_t LEVEL_CLOSED     = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    MOVE_UP,
    MOVE_DOWN
  } motor_state_t;

endpackage

// File: rtl/blinds_target_filter.sv
// Glitch filter on the requested level: a value must be sampled SETTLE times in a row
// before it is promoted to goal.
module blinds_target_filter
  import blinds_pkg::*;
#(
  parameter int SETTLE = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  level_t target,
  output level_t target_q,
  output level_t goal,
  output logic   goal_upd
);

  localparam int CW = $clog2(SETTLE + 1);

  level_t        target_q_reg;
  level_t        goal_reg;
  logic [CW-1:0] stab_cnt_reg;
  logic [CW-1:0] stab_cnt_next;

  // Counter saturates one past the accept point so the strobe fires once per stable run.
  always_comb begin
    stab_cnt_next = stab_cnt_reg;
    if (target != target_q_reg) begin
      stab_cnt_next = '0;
    end else if (stab_cnt_reg != CW'(SETTLE)) begin
      stab_cnt_next = stab_cnt_reg + CW'(1);
    end
  end

  assign goal_upd = (stab_cnt_reg == CW'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q_reg <= LEVEL_OPEN;
      stab_cnt_reg <= '0;
      goal_reg     <= LEVEL_OPEN;
    end else begin
      target_q_reg <= target;
      stab_cnt_reg <= stab_cnt_next;
      if (goal_upd) begin
        goal_reg <= target_q_reg;
      end
    end
  end

  assign target_q = target_q_reg;
  assign goal     = goal_reg;

endmodule

// File: rtl/blinds_motor_ctrl.sv
// Up/down blind motor controller: step-counted position, motor-off dwell before any
// start or reversal, and registered status outputs.
module blinds_motor_ctrl
  import blinds_pkg::*;
#(
  parameter int STEPS_PER_LEVEL = 100,
  parameter int SETTLE          = 8,
  parameter int DIR_DWELL       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] target,
  output logic       motor_up,
  output logic       motor_down,
  output logic [1:0] position,
  output logic       busy,
  output logic       at_target
);

  localparam int SW = $clog2(STEPS_PER_LEVEL);
  localparam int DW = $clog2(DIR_DWELL + 1);
  localparam logic [SW-1:0] SUB_MAX = SW'(STEPS_PER_LEVEL - 1);

  level_t target_q;
  level_t goal;
  level_t goal_next;
  logic   goal_upd;

  blinds_target_filter #(
    .SETTLE(SETTLE)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .target   (target),
    .target_q (target_q),
    .goal     (goal),
    .goal_upd (goal_upd)
  );

  assign goal_next = goal_upd ? target_q : goal;

  motor_state_t  state_reg, state_next;
  logic [DW-1:0] dwell_cnt_reg, dwell_cnt_next;
  level_t        level_reg, level_next;
  logic [SW-1:0] sub_reg, sub_next;
  logic          motor_up_reg, motor_up_next;
  logic          motor_down_reg, motor_down_next;
  logic          busy_reg, at_target_reg;
  logic          step_up, step_down;
  logic          arrived, need_up, need_down;

  // Level 3 only exists with sub==0, so blocking a down step there covers the closed end.
  assign step_down = motor_down_reg && (level_reg != LEVEL_CLOSED);
  assign step_up   = motor_up_reg && !((level_reg == LEVEL_OPEN) && (sub_reg == '0));

  always_comb begin
    level_next = level_reg;
    sub_next   = sub_reg;
    if (step_down) begin
      if (sub_reg == SUB_MAX) begin
        sub_next   = '0;
        level_next = level_reg + 2'd1;
      end else begin
        sub_next = sub_reg + SW'(1);
      end
    end else if (step_up) begin
      if (sub_reg == '0) begin
        sub_next   = SUB_MAX;
        level_next = level_reg - 2'd1;
      end else begin
        sub_next = sub_reg - SW'(1);
      end
    end
  end

  // Decisions use the position after this edge's step against the goal currently held.
  assign arrived   = (level_next == goal) && (sub_next == '0);
  assign need_down = (goal > level_next);
  assign need_up   = (level_next > goal) || ((level_next == goal) && (sub_next != '0));

  always_comb begin
    state_next      = state_reg;
    dwell_cnt_next  = dwell_cnt_reg;
    motor_up_next   = 1'b0;
    motor_down_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!arrived) begin
          state_next     = DWELL;
          dwell_cnt_next = '0;
        end
      end
      DWELL: begin
        if (dwell_cnt_reg == DW'(DIR_DWELL - 1)) begin
          if (need_down) begin
            state_next      = MOVE_DOWN;
            motor_down_next = 1'b1;
          end else if (need_up) begin
            state_next    = MOVE_UP;
            motor_up_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          dwell_cnt_next = dwell_cnt_reg + DW'(1);
        end
      end
      MOVE_DOWN: begin
        if (need_down) begin
          motor_down_next = 1'b1;
        end else if (need_up) begin
          state_next     = DWELL;
          dwell_cnt_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      MOVE_UP: begin
        if (need_up) begin
          motor_up_next = 1'b1;
        end else if (need_down) begin
          state_next     = DWELL;
          dwell_cnt_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      dwell_cnt_reg  <= '0;
      level_reg      <= LEVEL_OPEN;
      sub_reg        <= '0;
      motor_up_reg   <= 1'b0;
      motor_down_reg <= 1'b0;
      busy_reg       <= 1'b0;
      at_target_reg  <= 1'b1;
    end else begin
      state_reg      <= state_next;
      dwell_cnt_reg  <= dwell_cnt_next;
      level_reg      <= level_next;
      sub_reg        <= sub_next;
      motor_up_reg   <= motor_up_next;
      motor_down_reg <= motor_down_next;
      busy_reg       <= (state_next != IDLE);
      at_target_reg  <= (level_next == goal_next) && (sub_next == '0);
    end
  end

  assign motor_up   = motor_up_reg;
  assign motor_down = motor_down_reg;
  assign position   = level_reg;
  assign busy       = busy_reg;
  assign at_target  = at_target_reg;

endmodule

// File: tb/tb_blinds_motor_ctrl.sv
// Bench for blinds_motor_ctrl: integer step-position reference model compared every
// cycle, directed scenarios with literal expectations, then randomized targets.
module tb_blinds_motor_ctrl;

  localparam int SPL       = 4;
  localparam int SETTLE    = 3;
  localparam int DIR_DWELL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] target = 2'd0;
  logic       motor_up, motor_down, busy, at_target;
  logic [1:0] position;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  blinds_motor_ctrl #(
    .STEPS_PER_LEVEL(SPL),
    .SETTLE         (SETTLE),
    .DIR_DWELL      (DIR_DWELL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .target     (target),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .position   (position),
    .busy       (busy),
    .at_target  (at_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  // Reference model: absolute step position, motor direction, remaining dwell cycles,
  // and the run length of identical target samples.
  int m_pos = 0, m_goal = 0, m_motor = 0, m_dwell_left = 0;
  int m_run = 1, m_runval = 0;

  always @(posedge clk) begin
    int goal_steps;
    int diff;
    if (rst) begin
      m_pos = 0; m_goal = 0; m_motor = 0; m_dwell_left = 0;
      m_run = 1; m_runval = 0;
    end else begin
      goal_steps = m_goal * SPL;
      if (m_motor != 0) begin
        m_pos = m_pos + m_motor;
        diff  = goal_steps - m_pos;
        if (diff == 0) m_motor = 0;
        else if (sgn(diff) != m_motor) begin
          m_motor      = 0;
          m_dwell_left = DIR_DWELL;
        end
      end else if (m_dwell_left > 0) begin
        m_dwell_left--;
        if (m_dwell_left == 0) m_motor = sgn(goal_steps - m_pos);
      end else if (goal_steps != m_pos) begin
        m_dwell_left = DIR_DWELL;
      end
      if (m_run == SETTLE) m_goal = m_runval;
      if (int'(target) == m_runval) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_runval = int'(target);
        m_run    = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("motor_up",   int'(motor_up),   int'(m_motor == -1));
      chk("motor_down", int'(motor_down), int'(m_motor == 1));
      chk("position",   int'(position),   m_pos / SPL);
      chk("busy",       int'(busy),       int'((m_motor != 0) || (m_dwell_left > 0)));
      chk("at_target",  int'(at_target),  int'(m_pos == m_goal * SPL));
      chk("motor_excl", int'(motor_up & motor_down), 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; target = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) until the selected motor output is high; returns cycles waited.
  task automatic wait_motor(input bit down, output int k);
    k = 0;
    while (((down ? motor_down : motor_up) == 1'b0) && k < 60) begin
      @(negedge clk); k++;
    end
  endtask

  // Counts consecutive cycles the selected motor stays high; tracks position changes.
  task automatic count_high(input bit down, output int n, output int seq);
    int last;
    n = 0; seq = 0; last = int'(position);
    while (((down ? motor_down : motor_up) == 1'b1) && n < 60) begin
      @(negedge clk); n++;
      if (int'(position) != last) begin
        last = int'(position);
        seq  = seq * 10 + last;
      end
    end
  endtask

  initial begin
    int k, n, seq, hits;

    // Reset and idle behaviour
    rst = 1'b1; target = 2'd0;
    @(negedge clk); @(negedge clk);
    chk("t1_rst_motor_up",   int'(motor_up), 0);
    chk("t1_rst_motor_down", int'(motor_down), 0);
    chk("t1_rst_position",   int'(position), 0);
    chk("t1_rst_busy",       int'(busy), 0);
    chk("t1_rst_at_target",  int'(at_target), 1);
    cmp_en = 1'b1;
    rst = 1'b0;
    hits = 0;
    repeat (50) begin
      @(negedge clk);
      if (motor_up || motor_down || busy) hits++;
    end
    chk("t1_idle_activity", hits, 0);
    $display("scenario 1: reset and idle");

    // Full close 0 -> 3
    target = 2'd3;
    wait_motor(1'b1, k);
    chk("t2_start_latency", k - 1, 6);
    count_high(1'b1, n, seq);
    chk("t2_down_cycles", n, 12);
    chk("t2_position_seq", seq, 123);
    chk("t2_busy_end", int'(busy), 0);
    chk("t2_at_target_end", int'(at_target), 1);
    chk("t2_model_pos", m_pos, 12);
    $display("scenario 2: open to closed");

    // Reversal mid-move: start opening, request closed as soon as the motor starts
    target = 2'd0;
    wait_motor(1'b0, k);
    target = 2'd3;
    count_high(1'b0, n, seq);
    chk("t4_up_cycles", n, 5);
    k = 0;
    while (!motor_down && k < 20) begin
      @(negedge clk); k++;
      if (motor_up) hits++;
    end
    chk("t4_off_cycles", k, 2);
    count_high(1'b1, n, seq);
    chk("t4_down_cycles", n, 5);
    chk("t4_position_end", int'(position), 3);
    chk("t4_at_target_end", int'(at_target), 1);
    chk("t4_model_pos", m_pos, 12);
    $display("scenario 4: reversal");

    // Short glitch is filtered
    do_reset();
    @(negedge clk);
    target = 2'd2;
    @(negedge clk); @(negedge clk);
    target = 2'd0;
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (motor_up || motor_down || !at_target) hits++;
    end
    chk("t3_glitch_activity", hits, 0);
    chk("t3_model_goal", m_goal, 0);
    $display("scenario 3: glitch filtered");

    // Same-direction goal extension mid-move
    target = 2'd1;
    k = 0;
    while (!busy && k < 30) begin @(negedge clk); k++; end
    target = 2'd3;
    wait_motor(1'b1, k);
    count_high(1'b1, n, seq);
    chk("t5_down_cycles", n, 12);
    chk("t5_position_end", int'(position), 3);
    $display("scenario 5: extended move");

    // Reset while moving down
    do_reset();
    target = 2'd2;
    wait_motor(1'b1, k);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; target = 2'd1;
    @(negedge clk);
    chk("t6_motor_down_off", int'(motor_down), 0);
    chk("t6_position_zero", int'(position), 0);
    chk("t6_busy_low", int'(busy), 0);
    rst = 1'b0;
    wait_motor(1'b1, k);
    count_high(1'b1, n, seq);
    chk("t6_steps_after_rst", n, 4);
    chk("t6_position_end", int'(position), 1);
    $display("scenario 6: reset during move");

    // Randomized targets with random hold times and occasional resets
    for (int i = 0; i < 400; i++) begin
      int hold;
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
        $display("random %0d: reset", i);
      end
      hold = $urandom_range(1, 24);
      target = 2'($urandom_range(0, 3));
      $display("random %0d: target=%0d hold=%0d", i, target, hold);
      repeat (hold) @(negedge clk);
    end
    repeat (80) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
